fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//   Instruction fetch stage directly upstream of the main decoder.
//   - Holds the PC and fetches 32-bit instructions from instruction memory with a req/ack handshake.
//   - Buffers fetched words in a small FIFO.
//   - Presents the head instruction with pre-sliced decode fields (opcode, funct3, funct7 bit 5) under valid/ready.
//   - i_redirect flushes the FIFO and restarts fetch at a new PC (branch/jump).
//
// PARAMETERS
//   XLEN        32            PC / address width.
//   RESET_PC    32'h0000_0000 PC loaded on reset.
//   FIFO_DEPTH  2             Fetch buffer entries, >=1. Each entry holds {pc, instr}.
//
// PORTS
//   i_clk          in   1     Clock. All state updates on the rising edge.
//   i_arst_n       in   1     Asynchronous reset, active low.
//   o_imemReq      out  1     Fetch request to instruction memory.
//   o_imemAddr     out  XLEN  Fetch address. Stable while o_imemReq is high.
//   i_imemAck      in   1     Memory ack. Transfer completes when o_imemReq && i_imemAck.
//   i_imemData     in   32    Instruction word. Valid in the ack cycle.
//   i_redirect     in   1     Flush and restart fetch at i_redirectPc.
//   i_redirectPc   in   XLEN  Redirect target.
//   o_valid        out  1     FIFO head is valid.
//   i_ready        in   1     Consumer accepts head. Pop on o_valid && i_ready.
//   o_instr        out  32    Head instruction; 32'h0 when FIFO empty.
//   o_pc           out  XLEN  PC of head instruction; '0 when FIFO empty.
//   o_operand      out  7     o_instr[6:0]  (opcode; feeds decoder).
//   o_funct3       out  3     o_instr[14:12].
//   o_funct7bit5   out  1     o_instr[30].
//   o_misaligned   out  1     Present only with FETCH_MISALIGN_CHECK_EN (see CONFIGURATION).
//
// BEHAVIOUR
//   Reset (async assert, sync-safe release):
//     - pc=RESET_PC, FIFO empty, state=IDLE.
//     - All outputs 0 except o_imemAddr=RESET_PC; o_misaligned=0.
//   FSM states: IDLE, REQ, DROP. At most one request outstanding.
//     - IDLE -> REQ when FIFO count < FIFO_DEPTH and no redirect this cycle.
//       o_imemReq rises the cycle after the transition decision (registered), o_imemAddr=pc.
//     - REQ, ack, no redirect: push {pc, i_imemData}; pc += 4 (mod 2^XLEN, wraps);
//       return to IDLE. Next request can start the following cycle, so back-to-back
//       fetches have 1 idle cycle between acks.
//     - REQ, no ack, redirect: pc=i_redirectPc; FIFO flushed; -> DROP.
//       Req and address stay unchanged until ack.
//     - REQ, ack and redirect in the same cycle: data discarded; pc=i_redirectPc; FIFO flushed; -> IDLE.
//     - DROP, ack: data discarded -> IDLE. A further redirect in DROP only updates pc.
//     - IDLE, redirect: pc=i_redirectPc, FIFO flushed.
//   Request/ack rules:
//     - Never start a request when the FIFO is full.
//     - A pending request always has a free slot: count cannot grow while one is in flight.
//   FIFO:
//     - Push and pop in the same cycle are allowed at any count, including full.
//     - Pop when empty is ignored.
//     - Redirect flush takes priority over pop and push in that cycle;
//       o_valid is 0 the following cycle.
//     - Head outputs are combinational from the head entry; they change only on pop, push-to-empty, or flush.
//   Latency: redirect to first o_valid = 3 cycles with single-cycle ack (register pc, req, push).
//
// CONFIGURATION
//   FETCH_MISALIGN_CHECK_EN defined:
//     - A redirect with i_redirectPc[1:0] != 2'b00 still flushes the FIFO.
//     - It does not change pc and does not start fetching.
//     - o_misaligned is set and stays high (sticky) until the next aligned redirect or reset.
//     - Fetch is halted while o_misaligned is high.
//   Not defined: port absent. i_redirectPc[1:0] is ignored; pc loads {i_redirectPc[XLEN-1:2], 2'b00}.
//
// TESTING
//   1. Reset release, ack tied high, i_ready=1 -> o_pc sequence 0x0, 0x4, 0x8;
//      o_operand matches imem word[6:0].
//   2. i_ready=0, ack=1 -> exactly 2 pushes, then o_imemReq stays 0.
//      Raise i_ready -> pops in order 0x0, 0x4, and fetch resumes at 0x8.
//   3. Redirect to 0x100 while req pending (ack delayed 3 cycles) -> late data discarded;
//      next req address 0x100; first o_pc = 0x100.
//   4. Redirect in the same cycle as ack for 0x8 -> 0x8 never appears; FIFO empty next cycle.
//   5. pc = 0xFFFF_FFFC fetch -> next o_imemAddr = 0x0000_0000.
//   6. With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 -> o_misaligned=1, no req.
//      Then redirect to 0x200 -> o_misaligned=0, fetch from 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, req/ack imem fetch, {pc,instr} buffer, pre-sliced decode fields.
// Optional FETCH_MISALIGN_CHECK_EN adds o_misaligned and halts fetch on a misaligned redirect.
module fetch_unit #(
  parameter int unsigned    XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned    FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  output logic            o_imemReq,
  output logic [XLEN-1:0] o_imemAddr,
  input  logic            i_imemAck,
  input  logic [31:0]     i_imemData,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirectPc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_operand,
  output logic [2:0]      o_funct3,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            o_misaligned,
`endif
  output logic            o_funct7bit5
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]       state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  reqAddr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  pcMem    [FIFO_DEPTH];
  logic [31:0]      instrMem [FIFO_DEPTH];

  logic            fifoFull;
  logic            fifoEmpty;
  logic            push;
  logic            pop;
  logic            startReq;
  logic            redirectLoad;
  logic            fetchHalt;
  logic [XLEN-1:0] targetPc;

  assign targetPc = i_redirectPc & {{(XLEN-2){1'b1}}, 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  logic redirectBad;

  assign redirectBad  = i_redirect && (i_redirectPc[1:0] != 2'b00);
  assign redirectLoad = i_redirect && !redirectBad;
  assign fetchHalt    = misaligned;
  assign o_misaligned = misaligned;

  // Sticky until the next redirect; a misaligned one re-arms it.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      misaligned <= 1'b0;
    end else if (i_redirect) begin
      misaligned <= redirectBad;
    end
  end
`else
  assign redirectLoad = i_redirect;
  assign fetchHalt    = 1'b0;
`endif

  assign fifoFull  = (count == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (count == '0);
  assign push      = (state == REQ) && i_imemAck && !i_redirect;
  assign pop       = !fifoEmpty && i_ready && !i_redirect;
  assign startReq  = (state == IDLE) && !fifoFull && !i_redirect && !fetchHalt;

  assign o_imemReq  = (state != IDLE);
  assign o_imemAddr = (state == IDLE) ? pc : reqAddr;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      reqAddr <= RESET_PC;
    end else begin
      case (state)
        IDLE: if (startReq) state <= REQ;
        REQ: begin
          if (i_imemAck)       state <= IDLE;
          else if (i_redirect) state <= DROP;
        end
        DROP: if (i_imemAck) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (startReq) reqAddr <= pc;
      if (redirectLoad) begin
        pc <= targetPc;
      end else if (push) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

  // Flush wins over push and pop in the same cycle.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (i_redirect) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= (wrPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= (rdPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      pcMem[wrPtr]    <= reqAddr;
      instrMem[wrPtr] <= i_imemData;
    end
  end

  assign o_valid      = !fifoEmpty;
  assign o_instr      = fifoEmpty ? 32'h0 : instrMem[rdPtr];
  assign o_pc         = fifoEmpty ? '0 : pcMem[rdPtr];
  assign o_operand    = o_instr[6:0];
  assign o_funct3     = o_instr[14:12];
  assign o_funct7bit5 = o_instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (queue model plus directed vectors).
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck;
  logic [31:0] i_imemData;
  logic        i_redirect;
  logic [31:0] i_redirectPc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [6:0]  o_operand;
  logic [2:0]  o_funct3;
  logic        o_funct7bit5;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        o_misaligned;
`endif

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] imemWord(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5A5_5A5A;
  endfunction

  assign i_imemData = imemWord(o_imemAddr);

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .o_imemReq(o_imemReq), .o_imemAddr(o_imemAddr),
    .i_imemAck(i_imemAck), .i_imemData(i_imemData),
    .i_redirect(i_redirect), .i_redirectPc(i_redirectPc),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_pc(o_pc), .o_operand(o_operand),
    .o_funct3(o_funct3),
`ifdef FETCH_MISALIGN_CHECK_EN
    .o_misaligned(o_misaligned),
`endif
    .o_funct7bit5(o_funct7bit5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q[$];
  logic [31:0] expPc = 32'h0;
  bit          drop = 1'b0;
  bit          expMis = 1'b0;
  bit          modelOn = 1'b0;
  int          prevQSize = 0;
  bit          prevMis = 1'b0;
  bit          prevReq = 1'b0;
  bit          prevHold = 1'b0;
  logic [31:0] prevAddr = 32'h0;

  logic [31:0] popLog[$];
  logic [31:0] reqLog[$];
  logic [6:0]  opLog[$];
  int          ackCount = 0;

  function automatic logic [31:0] logAt(input logic [31:0] lq[$], input int i);
    return (i < lq.size()) ? lq[i] : 32'hDEAD_BEEF;
  endfunction

  // Model: the buffer is a queue of fetched {pc, word}; a redirect empties it and
  // any request still in flight at that moment returns data that must be thrown away.
  always @(negedge i_clk) begin
    if (modelOn) begin
      check("valid", 32'(o_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("pc", o_pc, q[0].pc);
        check("instr", o_instr, q[0].instr);
        check("operand", 32'(o_operand), 32'(q[0].instr[6:0]));
        check("funct3", 32'(o_funct3), 32'(q[0].instr[14:12]));
        check("funct7bit5", 32'(o_funct7bit5), 32'(q[0].instr[30]));
      end else begin
        check("pcEmpty", o_pc, 32'h0);
        check("instrEmpty", o_instr, 32'h0);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      check("misaligned", 32'(o_misaligned), 32'(expMis));
`endif
      if (o_imemReq && !prevReq) begin
        check("reqWhenFull", 32'(prevQSize < DEPTH), 32'd1);
        check("reqWhenHalted", 32'(prevMis), 32'd0);
        reqLog.push_back(o_imemAddr);
      end
      if (prevHold) begin
        check("reqHeld", 32'(o_imemReq), 32'd1);
        check("addrStable", o_imemAddr, prevAddr);
      end
      if (o_imemReq && !drop) check("reqAddr", o_imemAddr, expPc);
      if (o_valid && i_ready && !i_redirect) begin
        popLog.push_back(o_pc);
        opLog.push_back(o_operand);
      end
      if (o_imemReq && i_imemAck && !i_redirect && !drop) ackCount++;

      prevQSize = q.size();
      prevMis   = expMis;
      prevReq   = o_imemReq;
      prevHold  = o_imemReq && !i_imemAck;
      prevAddr  = o_imemAddr;
      if (i_redirect) begin
        q.delete();
        drop = o_imemReq && !i_imemAck;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (i_redirectPc[1:0] != 2'b00) begin
          expMis = 1'b1;
        end else begin
          expMis = 1'b0;
          expPc  = i_redirectPc;
        end
`else
        expPc = {i_redirectPc[31:2], 2'b00};
`endif
      end else begin
        if (o_valid && i_ready && q.size() != 0) void'(q.pop_front());
        if (o_imemReq && i_imemAck) begin
          if (drop) begin
            drop = 1'b0;
          end else begin
            q.push_back('{pc: expPc, instr: imemWord(expPc)});
            expPc = expPc + 32'd4;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic redirectTo(input logic [31:0] target);
    i_redirect   = 1'b1;
    i_redirectPc = target;
    tick(1);
    i_redirect   = 1'b0;
  endtask

  initial begin
    int n;
    i_arst_n     = 1'b0;
    i_imemAck    = 1'b0;
    i_redirect   = 1'b0;
    i_redirectPc = 32'h0;
    i_ready      = 1'b0;
    tick(3);
    check("rstReq", 32'(o_imemReq), 32'd0);
    check("rstAddr", o_imemAddr, 32'h0);
    check("rstValid", 32'(o_valid), 32'd0);
    check("rstInstr", o_instr, 32'h0);
    check("rstPc", o_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rstMisaligned", 32'(o_misaligned), 32'd0);
`endif

    // Sequential fetch, ack tied high, consumer always ready.
    i_arst_n  = 1'b1;
    i_imemAck = 1'b1;
    i_ready   = 1'b1;
    modelOn   = 1'b1;
    tick(10);
    check("t1Pop0", logAt(popLog, 0), 32'h0);
    check("t1Pop1", logAt(popLog, 1), 32'h4);
    check("t1Pop2", logAt(popLog, 2), 32'h8);
    check("t1Opcode0", 32'((opLog.size() > 0) ? opLog[0] : 7'h7F), 32'h5A);

    // Stalled consumer: buffer fills with exactly two words and fetch stops.
    i_ready = 1'b0;
    redirectTo(32'h0);
    ackCount = 0;
    tick(10);
    check("t2Pushes", 32'(ackCount), 32'd2);
    check("t2ReqIdle", 32'(o_imemReq), 32'd0);
    check("t2HeadPc", o_pc, 32'h0);
    popLog.delete();
    reqLog.delete();
    i_ready = 1'b1;
    tick(8);
    check("t2Pop0", logAt(popLog, 0), 32'h0);
    check("t2Pop1", logAt(popLog, 1), 32'h4);
    check("t2Resume", logAt(reqLog, 0), 32'h8);

    // Redirect while a request waits for a slow ack.
    i_imemAck = 1'b0;
    n = 0;
    while (!o_imemReq && n < 20) begin
      tick(1);
      n++;
    end
    check("t3ReqSeen", 32'(n < 20), 32'd1);
    redirectTo(32'h100);
    reqLog.delete();
    popLog.delete();
    tick(2);
    check("t3EmptyBeforeAck", 32'(o_valid), 32'd0);
    i_imemAck = 1'b1;
    tick(10);
    check("t3FirstReq", logAt(reqLog, 0), 32'h100);
    check("t3FirstPop", logAt(popLog, 0), 32'h100);

    // Redirect coincides with the ack for 0x8.
    redirectTo(32'h8);
    i_imemAck = 1'b0;
    n = 0;
    while (!(o_imemReq && o_imemAddr == 32'h8) && n < 20) begin
      tick(1);
      n++;
    end
    check("t4ReqSeen", 32'(n < 20), 32'd1);
    i_imemAck = 1'b1;
    redirectTo(32'h40);
    check("t4EmptyAfter", 32'(o_valid), 32'd0);
    popLog.delete();
    tick(10);
    check("t4FirstPop", logAt(popLog, 0), 32'h40);

    // PC wrap at the top of the address space; flush empties a non-empty buffer.
    i_ready = 1'b0;
    tick(6);
    check("t5FullBefore", 32'(o_valid), 32'd1);
    redirectTo(32'hFFFF_FFFC);
    check("t5FlushValid", 32'(o_valid), 32'd0);
    i_ready = 1'b1;
    reqLog.delete();
    popLog.delete();
    tick(10);
    check("t5Req0", logAt(reqLog, 0), 32'hFFFF_FFFC);
    check("t5Req1", logAt(reqLog, 1), 32'h0);
    check("t5Pop1", logAt(popLog, 1), 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirectTo(32'h102);
    check("t6MisSet", 32'(o_misaligned), 32'd1);
    reqLog.delete();
    tick(6);
    check("t6NoReq", 32'(reqLog.size()), 32'd0);
    check("t6ReqLow", 32'(o_imemReq), 32'd0);
    check("t6Empty", 32'(o_valid), 32'd0);
    redirectTo(32'h200);
    check("t6MisClear", 32'(o_misaligned), 32'd0);
    popLog.delete();
    tick(8);
    check("t6FirstPop", logAt(popLog, 0), 32'h200);
`else
    redirectTo(32'h102);
    reqLog.delete();
    popLog.delete();
    tick(8);
    check("t6AlignReq", logAt(reqLog, 0), 32'h100);
    check("t6AlignPop", logAt(popLog, 0), 32'h100);
`endif

    tick(2);
    modelOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
